writeback_unit: RTL and testbench

- Producer side of the register file: collects completed results from the ALU and the load/store unit (LSU).
- Buffers the results in a small in-order queue and issues at most one register-file write per cycle on the wr_en/wr_addr/wr_data interface.
- Keeps a pending-destination mask so issue logic can stall on read-after-write hazards before reading rd_addr1/rd_addr2.

---
 rtl/core_pkg.sv | 18 +
 rtl/wb_fifo.sv | 69 ++++++
 rtl/writeback_unit.sv | 84 ++++++++
 tb/tb_writeback_unit.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// +----------------------------------------------------------------------------+
// | core_pkg: register-file geometry and write-back entry layout                |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

package core_pkg;
  localparam int REG_ADDR_W   = 5;
  localparam int NUM_REGS     = 32;
  localparam int XLEN_DEFAULT = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0]   rd;
    logic [XLEN_DEFAULT-1:0] data;
  } wb_entry_t;
endpackage

`default_nettype wire

// File: rtl/wb_fifo.sv
// +----------------------------------------------------------------------------+
// | wb_fifo: circular queue accepting up to two pushes and one pop per cycle    |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module wb_fifo #(
  parameter  int DEPTH = 4,
  parameter  int W     = 37,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push0_i,
  input  logic [W-1:0]  data0_i,
  input  logic          push1_i,
  input  logic [W-1:0]  data1_i,
  input  logic          pop_i,
  output logic [CW-1:0] count_o,
  output logic [W-1:0]  head_o
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("wb_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [1:0]    w_n_push;
  logic [AW-1:0] w_idx1;

  always_comb begin
    w_n_push = {1'b0, push0_i} + {1'b0, push1_i};
    // Second push lands behind the first only when both are present.
    w_idx1   = push0_i ? tail_q + AW'(1) : tail_q;
    tail_d   = tail_q + AW'(w_n_push);
    head_d   = head_q + AW'(pop_i);
    count_d  = count_q + CW'(w_n_push) - CW'(pop_i);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push0_i) mem_q[tail_q] <= data0_i;
    if (push1_i) mem_q[w_idx1] <= data1_i;
  end

  assign count_o = count_q;
  assign head_o  = mem_q[head_q];

  a_no_overflow: assert property (@(posedge clk) disable iff (reset) count_q <= DEPTH_C);

endmodule

`default_nettype wire

// File: rtl/writeback_unit.sv
// +----------------------------------------------------------------------------+
// | writeback_unit: arbitrates ALU/LSU results into one register-file write     |
// | port and tracks pending destinations. Revision: 1.0                         |
// +----------------------------------------------------------------------------+
`default_nettype none

module writeback_unit
  import core_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  alu_valid,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]       alu_data,
  output logic                  alu_ready,
  input  logic                  lsu_valid,
  input  logic [REG_ADDR_W-1:0] lsu_rd,
  input  logic [XLEN-1:0]       lsu_data,
  output logic                  lsu_ready,
  input  logic                  mark_valid,
  input  logic [REG_ADDR_W-1:0] mark_rd,
  output logic                  wr_en,
  output logic [REG_ADDR_W-1:0] wr_addr,
  output logic [XLEN-1:0]       wr_data,
  output logic [NUM_REGS-1:0]   busy_mask
);

  localparam int              EW      = REG_ADDR_W + XLEN;
  localparam int              CW      = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);

  logic [CW-1:0]       w_count, w_free;
  logic [EW-1:0]       w_head;
  logic                w_lsu_push, w_alu_push;
  logic [NUM_REGS-1:0] busy_q, busy_d;

  // Credit comes from the registered count only; a same-cycle pop is not reused.
  assign w_free    = DEPTH_C - w_count;
  assign lsu_ready = (w_free != '0);
  assign alu_ready = (w_free >= CW'(2)) || ((w_free == CW'(1)) && !lsu_valid);

  // Results for x0 finish their handshake but never occupy a slot.
  assign w_lsu_push = lsu_valid && lsu_ready && (lsu_rd != '0);
  assign w_alu_push = alu_valid && alu_ready && (alu_rd != '0);

  wb_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push0_i (w_lsu_push),
    .data0_i ({lsu_rd, lsu_data}),
    .push1_i (w_alu_push),
    .data1_i ({alu_rd, alu_data}),
    .pop_i   (wr_en),
    .count_o (w_count),
    .head_o  (w_head)
  );

  assign wr_en   = (w_count != '0);
  assign wr_addr = wr_en ? w_head[EW-1 -: REG_ADDR_W] : '0;
  assign wr_data = wr_en ? w_head[XLEN-1:0] : '0;

  always_comb begin
    busy_d = busy_q;
    if (wr_en) busy_d[wr_addr] = 1'b0;
    if (mark_valid && (mark_rd != '0)) busy_d[mark_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  assign busy_mask = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_writeback_unit.sv
// +----------------------------------------------------------------------------+
// | tb_writeback_unit: directed self-checking bench for writeback_unit          |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_writeback_unit;
  import core_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid, lsu_valid, mark_valid;
  logic [4:0]  alu_rd, lsu_rd, mark_rd;
  logic [31:0] alu_data, lsu_data;
  logic        alu_ready, lsu_ready, wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [31:0] busy_mask;

  int checks   = 0;
  int failures = 0;

  logic [4:0]  cap_addr[$];
  logic [31:0] cap_data[$];
  wb_entry_t   exp_q[$];

  always #5 clk = ~clk;

  writeback_unit #(.DEPTH(4), .XLEN(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .alu_valid  (alu_valid),
    .alu_rd     (alu_rd),
    .alu_data   (alu_data),
    .alu_ready  (alu_ready),
    .lsu_valid  (lsu_valid),
    .lsu_rd     (lsu_rd),
    .lsu_data   (lsu_data),
    .lsu_ready  (lsu_ready),
    .mark_valid (mark_valid),
    .mark_rd    (mark_rd),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy_mask  (busy_mask)
  );

  // Record every register-file write seen in mid-cycle.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      cap_addr.push_back(wr_addr);
      cap_data.push_back(wr_data);
    end
  end

  task automatic idle_inputs();
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
    mark_valid = 0; mark_rd = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    @(negedge clk); #1;
    checks++; if (wr_en !== 1'b0) begin failures++; $display("FAIL reset_wr_en got=%0b exp=0", wr_en); end
    checks++; if (wr_addr !== 5'd0) begin failures++; $display("FAIL reset_wr_addr got=%0d exp=0", wr_addr); end
    checks++; if (wr_data !== 32'd0) begin failures++; $display("FAIL reset_wr_data got=%h exp=0", wr_data); end
    checks++; if (busy_mask !== 32'd0) begin failures++; $display("FAIL reset_busy got=%h exp=0", busy_mask); end
    checks++; if ({lsu_ready, alu_ready} !== 2'b11) begin failures++; $display("FAIL reset_ready got=%b exp=11", {lsu_ready, alu_ready}); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_alu_single();
    @(negedge clk);
    alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
    #1;
    checks++; if (alu_ready !== 1'b1) begin failures++; $display("FAIL single_alu_ready got=%0b exp=1", alu_ready); end
    checks++; if (wr_en !== 1'b0) begin failures++; $display("FAIL single_no_bypass got=%0b exp=0", wr_en); end
    @(negedge clk);
    alu_valid = 0;
    #1;
    checks++; if (wr_en !== 1'b1) begin failures++; $display("FAIL single_wr_en got=%0b exp=1", wr_en); end
    checks++; if (wr_addr !== 5'd5) begin failures++; $display("FAIL single_wr_addr got=%0d exp=5", wr_addr); end
    checks++; if (wr_data !== 32'hDEADBEEF) begin failures++; $display("FAIL single_wr_data got=%h exp=deadbeef", wr_data); end
    @(negedge clk); #1;
    checks++; if (wr_en !== 1'b0) begin failures++; $display("FAIL single_drained got=%0b exp=0", wr_en); end
  endtask

  task automatic test_same_rd();
    @(negedge clk);
    mark_valid = 1; mark_rd = 7;
    @(negedge clk);
    mark_valid = 0;
    lsu_valid = 1; lsu_rd = 7; lsu_data = 32'h11111111;
    alu_valid = 1; alu_rd = 7; alu_data = 32'h22222222;
    #1;
    checks++; if (busy_mask !== 32'h0000_0080) begin failures++; $display("FAIL same_busy_set got=%h exp=00000080", busy_mask); end
    checks++; if ({lsu_ready, alu_ready} !== 2'b11) begin failures++; $display("FAIL same_ready got=%b exp=11", {lsu_ready, alu_ready}); end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++; if ({wr_en, wr_addr, wr_data} !== {1'b1, 5'd7, 32'h11111111}) begin failures++; $display("FAIL same_first got=%0b/%0d/%h exp=1/7/11111111", wr_en, wr_addr, wr_data); end
    checks++; if (busy_mask[7] !== 1'b1) begin failures++; $display("FAIL same_busy_held got=%0b exp=1", busy_mask[7]); end
    @(negedge clk); #1;
    checks++; if ({wr_en, wr_addr, wr_data} !== {1'b1, 5'd7, 32'h22222222}) begin failures++; $display("FAIL same_second got=%0b/%0d/%h exp=1/7/22222222", wr_en, wr_addr, wr_data); end
    @(negedge clk); #1;
    checks++; if (wr_en !== 1'b0) begin failures++; $display("FAIL same_drained got=%0b exp=0", wr_en); end
    checks++; if (busy_mask !== 32'd0) begin failures++; $display("FAIL same_busy_clear got=%h exp=0", busy_mask); end
  endtask

  task automatic test_busy_set_wins();
    @(negedge clk);
    alu_valid = 1; alu_rd = 9; alu_data = 32'h99;
    mark_valid = 1; mark_rd = 0;
    @(negedge clk);
    alu_valid = 0;
    mark_valid = 1; mark_rd = 9;   // set collides with the pop of rd 9
    #1;
    checks++; if (busy_mask !== 32'd0) begin failures++; $display("FAIL busy_x0_mark got=%h exp=0", busy_mask); end
    checks++; if (wr_addr !== 5'd9) begin failures++; $display("FAIL busy_head got=%0d exp=9", wr_addr); end
    @(negedge clk);
    mark_valid = 0; mark_rd = 0;
    #1;
    checks++; if (busy_mask !== 32'h0000_0200) begin failures++; $display("FAIL busy_set_wins got=%h exp=00000200", busy_mask); end
  endtask

  task automatic test_x0();
    cap_addr.delete(); cap_data.delete();
    @(negedge clk);
    alu_valid = 1; alu_rd = 0; alu_data = 32'hFFFFFFFF;
    #1;
    checks++; if (alu_ready !== 1'b1) begin failures++; $display("FAIL x0_alu_ready got=%0b exp=1", alu_ready); end
    @(negedge clk);
    alu_valid = 1; alu_rd = 3; alu_data = 32'h33;
    lsu_valid = 1; lsu_rd = 0; lsu_data = 32'hFFFFFFFF;
    #1;
    checks++; if ({wr_en, lsu_ready} !== 2'b01) begin failures++; $display("FAIL x0_no_write got=%b exp=01", {wr_en, lsu_ready}); end
    @(negedge clk);
    idle_inputs();
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (cap_addr.size() != 1 || cap_addr[0] !== 5'd3 || cap_data[0] !== 32'h33) begin
      failures++; $display("FAIL x0_writes got_n=%0d exp_n=1 (rd3=33)", cap_addr.size());
    end
  endtask

  task automatic test_back_to_back();
    // Per cycle: lsu_valid, lsu_rd, alu_valid, alu_rd, expected {lsu_ready, alu_ready}
    logic [12:0] vec [6];
    vec[0] = {1'b1, 5'd1, 1'b1, 5'd2, 1'b1};
    vec[1] = {1'b1, 5'd3, 1'b1, 5'd4, 1'b1};
    vec[2] = {1'b1, 5'd5, 1'b1, 5'd6, 1'b0};
    vec[3] = {1'b0, 5'd0, 1'b1, 5'd6, 1'b1};
    vec[4] = {1'b1, 5'd7, 1'b1, 5'd8, 1'b0};
    vec[5] = {1'b0, 5'd0, 1'b1, 5'd8, 1'b1};
    cap_addr.delete(); cap_data.delete(); exp_q.delete();
    for (int i = 1; i <= 8; i++) exp_q.push_back('{rd: 5'(i), data: 32'h1000_0000 + 32'(i)});
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      lsu_valid = vec[c][12]; lsu_rd = vec[c][11:7]; lsu_data = 32'h1000_0000 + 32'(vec[c][11:7]);
      alu_valid = vec[c][6];  alu_rd = vec[c][5:1];  alu_data = 32'h1000_0000 + 32'(vec[c][5:1]);
      #1;
      checks++;
      if ({lsu_ready, alu_ready} !== {1'b1, vec[c][0]}) begin
        failures++; $display("FAIL b2b_ready cycle=%0d got=%b exp=%b", c, {lsu_ready, alu_ready}, {1'b1, vec[c][0]});
      end
    end
    @(negedge clk);
    idle_inputs();
    repeat (4) @(negedge clk);
    #1;
    checks++;
    if (cap_addr.size() != exp_q.size()) begin
      failures++; $display("FAIL b2b_count got=%0d exp=%0d", cap_addr.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (cap_addr[i] !== exp_q[i].rd || cap_data[i] !== exp_q[i].data) begin
          failures++; $display("FAIL b2b_order idx=%0d got=%0d/%h exp=%0d/%h", i, cap_addr[i], cap_data[i], exp_q[i].rd, exp_q[i].data);
        end
      end
    end
    checks++; if (wr_en !== 1'b0) begin failures++; $display("FAIL b2b_drained got=%0b exp=0", wr_en); end
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    lsu_valid = 1; lsu_rd = 10; lsu_data = 32'hA;
    alu_valid = 1; alu_rd = 11; alu_data = 32'hB;
    mark_valid = 1; mark_rd = 12;
    @(negedge clk);
    lsu_rd = 12; lsu_data = 32'hC;
    alu_rd = 13; alu_data = 32'hD;
    mark_valid = 0;
    @(negedge clk);
    idle_inputs();
    #1;
    checks++; if ({wr_en, wr_addr} !== {1'b1, 5'd11}) begin failures++; $display("FAIL mid_pre got=%0b/%0d exp=1/11", wr_en, wr_addr); end
    #1 reset = 1'b1;
    #1;
    checks++; if ({wr_en, wr_addr, wr_data} !== 38'd0) begin failures++; $display("FAIL mid_async got=%0b/%0d/%h exp=0/0/0", wr_en, wr_addr, wr_data); end
    checks++; if (busy_mask !== 32'd0) begin failures++; $display("FAIL mid_busy got=%h exp=0", busy_mask); end
    @(negedge clk);
    reset = 1'b0;
    cap_addr.delete(); cap_data.delete();
    repeat (4) @(negedge clk);
    #1;
    checks++; if (cap_addr.size() != 0 || wr_en !== 1'b0) begin failures++; $display("FAIL mid_after got_writes=%0d exp=0", cap_addr.size()); end
  endtask

  initial begin
    test_reset();
    test_alu_single();
    test_same_rd();
    test_busy_set_wins();
    test_x0();
    test_back_to_back();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
